if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; drives the decode stage's pc_4/instruction inputs.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_skid_buffer.sv | 27 ++
 rtl/if_stage.sv | 110 +++++++++++
 tb/tb_if_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch stage.
// Used by if_stage and if_skid_buffer.
package if_stage_pkg;

   typedef logic [31:0] word_t;

   localparam word_t IF_RESET_PC = 32'h0000_0000;
   localparam word_t IF_NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   function automatic word_t pc_plus4(input word_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetch response that lands while
// decode is stalled; drained when the stall releases.
module if_skid_buffer
   import if_stage_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        capture,
   input  logic        drain,
   input  logic [31:0] word,
   output logic        valid,
   output logic [31:0] data
);

   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (capture) begin
         valid <= 1'b1;
         data  <= word;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// MIPS IF stage: PC, single-outstanding fetch, IF/ID register.
// Define IF_BRANCH_FLUSH_EN to squash the delay slot after a redirect.
module if_stage
   import if_stage_pkg::*;
#(
   parameter word_t RESET_PC = IF_RESET_PC,
   parameter word_t NOP_WORD = IF_NOP_WORD
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        shouldStall,
   input  logic        shouldJumpOrBranch,
   input  logic [31:0] jumpOrBranchPc,
   output logic        imemRequest,
   output logic [31:0] imemAddress,
   input  logic        imemReady,
   input  logic [31:0] imemData,
   output logic [31:0] pc_4,
   output logic [31:0] instruction,
   output logic        fetchBusy,
   output logic [31:0] debug_pc
);

   state_t state;
   word_t  pc;
   word_t  target;
   word_t  pc_next;
   word_t  held;
   word_t  fetched;
   logic   pending;
   logic   redirect;
   logic   done;
   logic   capture;
   logic   advance;
   logic   squash;
   logic   held_valid;

   assign redirect = shouldJumpOrBranch & ~shouldStall;
   assign done     = (state == S_FETCH) & imemReady;
   assign capture  = done & shouldStall;
   assign advance  = ~shouldStall & (done | held_valid);
   assign fetched  = held_valid ? held : imemData;

`ifdef IF_BRANCH_FLUSH_EN
   assign squash = redirect | pending;
`else
   assign squash = 1'b0;
`endif

   always_comb begin
      pc_next = pc_plus4(pc);
      if (pending)
         pc_next = target;
      else if (redirect)
         pc_next = jumpOrBranchPc;
   end

   if_skid_buffer u_skid (
      .clock   (clock),
      .reset   (reset),
      .capture (capture),
      .drain   (advance),
      .word    (imemData),
      .valid   (held_valid),
      .data    (held)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         target      <= RESET_PC;
         pending     <= 1'b0;
         pc_4        <= pc_plus4(RESET_PC);
         instruction <= NOP_WORD;
      end else begin
         if (advance) begin
            pc          <= pc_next;
            pc_4        <= pc_plus4(pc);
            instruction <= squash ? NOP_WORD : fetched;
            pending     <= 1'b0;
         end else begin
            // redirect must wait for the in-flight word
            if (redirect) begin
               pending <= 1'b1;
               target  <= jumpOrBranchPc;
            end
            if (state == S_FETCH && !shouldStall)
               instruction <= NOP_WORD;
         end
         unique case (state)
            S_IDLE:  state <= S_FETCH;
            S_FETCH: if (capture) state <= S_FULL;
            S_FULL:  if (!shouldStall) state <= S_FETCH;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign imemRequest = (state == S_FETCH);
   assign imemAddress = {pc[31:2], 2'b00};
   assign fetchBusy   = imemRequest & ~imemReady;
   assign debug_pc    = pc;

   a_one_redirect: assert property (
      @(posedge clock) disable iff (reset)
      !(pending && redirect)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed plus random checks of if_stage against a
// transaction-level fetch model.
module tb_if_stage;

   typedef logic [31:0] w32;

   localparam w32 NOP = 32'h0000_0000;
   localparam w32 RPC = 32'h0000_0000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic shouldStall = 1'b0;
   logic shouldJumpOrBranch = 1'b0;
   logic imemReady = 1'b0;
   w32   jumpOrBranchPc = '0;
   w32   imemData = '0;
   logic imemRequest;
   logic fetchBusy;
   w32   imemAddress;
   w32   pc_4;
   w32   instruction;
   w32   debug_pc;

   int checks = 0;
   int failures = 0;

   bit m_req;
   bit m_pend;
   w32 m_pc;
   w32 m_pc4;
   w32 m_instr;
   w32 m_tgt;
   w32 held_q[$];

   if_stage dut (
      .clock              (clock),
      .reset              (reset),
      .shouldStall        (shouldStall),
      .shouldJumpOrBranch (shouldJumpOrBranch),
      .jumpOrBranchPc     (jumpOrBranchPc),
      .imemRequest        (imemRequest),
      .imemAddress        (imemAddress),
      .imemReady          (imemReady),
      .imemData           (imemData),
      .pc_4               (pc_4),
      .instruction        (instruction),
      .fetchBusy          (fetchBusy),
      .debug_pc           (debug_pc)
   );

   always #5 clock = ~clock;

   function automatic w32 mem(input w32 a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
   endfunction

   function automatic w32 slot(input w32 a);
`ifdef IF_BRANCH_FLUSH_EN
      return NOP;
`else
      return mem(a);
`endif
   endfunction

   task automatic chk(input string tag, input w32 obs,
                      input w32 exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_req   = 1'b0;
      m_pend  = 1'b0;
      m_pc    = RPC;
      m_pc4   = RPC + 32'd4;
      m_instr = NOP;
      m_tgt   = RPC;
      held_q.delete();
   endtask

   task automatic check_regs();
      chk("pc_4", pc_4, m_pc4);
      chk("instruction", instruction, m_instr);
      chk("debug_pc", debug_pc, m_pc);
      chk("imemRequest", {31'd0, imemRequest}, {31'd0, m_req});
      chk("imemAddress", imemAddress, m_pc);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      imemReady = 1'b0;
      shouldJumpOrBranch = 1'b0;
      shouldStall = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         model_reset();
         @(negedge clock);
         check_regs();
      end
      reset = 1'b0;
   endtask

   task automatic step(input bit rdy, input bit stl,
                       input bit jb, input w32 tg);
      bit r;
      bit redir;
      bit go;
      bit sq;
      w32 w;
      w32 nxt;
      r = rdy & m_req;
      imemReady = r;
      shouldStall = stl;
      shouldJumpOrBranch = jb & !m_pend;
      jumpOrBranchPc = tg;
      imemData = r ? mem(m_pc) : w32'($urandom);
      #1;
      chk("fetchBusy", {31'd0, fetchBusy},
          {31'd0, m_req & !r});
      @(posedge clock);
      redir = shouldJumpOrBranch & !stl;
      go = !stl && (r || held_q.size() != 0);
      nxt = m_pend ? m_tgt : redir ? tg : m_pc + 32'd4;
      if (go) begin
`ifdef IF_BRANCH_FLUSH_EN
         sq = redir | m_pend;
`else
         sq = 1'b0;
`endif
         w = held_q.size() != 0 ? held_q.pop_front()
                                : mem(m_pc);
         m_pc4   = m_pc + 32'd4;
         m_instr = sq ? NOP : w;
         m_pc    = nxt;
         m_pend  = 1'b0;
         m_req   = 1'b1;
      end else begin
         if (redir) begin
            m_pend = 1'b1;
            m_tgt  = tg;
         end
         if (m_req && r && stl) begin
            held_q.push_back(mem(m_pc));
            m_req = 1'b0;
         end else if (m_req && !stl) begin
            m_instr = NOP;
         end else if (!m_req && held_q.size() == 0) begin
            m_req = 1'b1;
         end
      end
      @(negedge clock);
      check_regs();
   endtask

   task automatic run_to(input w32 a);
      for (int i = 0; i < 256 && m_pc != a; i++)
         step(1'b1, 1'b0, 1'b0, '0);
      chk("run_to", imemAddress, a);
   endtask

   initial begin
      do_reset(2);
      chk("rst_req", {31'd0, imemRequest}, '0);
      chk("rst_pc4", pc_4, RPC + 32'd4);
      chk("rst_instr", instruction, NOP);

      step(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
         chk("seq_addr", imemAddress, w32'(k * 4));
         step(1'b1, 1'b0, 1'b0, '0);
         chk("seq_instr", instruction, mem(w32'(k * 4)));
         chk("seq_pc4", pc_4, w32'(k * 4 + 4));
      end

      run_to(32'h10);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, 1'b0, '0);
         chk("bubble", instruction, NOP);
         chk("wait_addr", imemAddress, 32'h10);
      end
      step(1'b1, 1'b0, 1'b0, '0);
      chk("after_wait", instruction, mem(32'h10));

      run_to(32'h20);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b0, '0);
         chk("full_noreq", {31'd0, imemRequest}, '0);
      end
      step(1'b1, 1'b0, 1'b0, '0);
      chk("release_instr", instruction, mem(32'h20));
      chk("release_pc4", pc_4, 32'h24);

      run_to(32'h40);
      step(1'b1, 1'b0, 1'b1, 32'h100);
      chk("delay_slot", instruction, slot(32'h40));
      chk("branch_addr", imemAddress, 32'h100);

      step(1'b0, 1'b0, 1'b0, '0);
      do_reset(2);
      chk("midrst_pc", debug_pc, RPC);

      run_to(32'h44);
      step(1'b0, 1'b0, 1'b1, 32'h200);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      chk("pend_slot", instruction, slot(32'h44));
      chk("pend_addr", imemAddress, 32'h200);

      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      chk("wrap_addr", imemAddress, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0)
            do_reset($urandom_range(1, 2));
         else
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom & 32'hFFFF_FFFC);
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
